// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 4-channel mux scan controller.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Settle-window counter: counts up while enabled and flags done when it reaches SETTLE.
module mux_scan_settle_cnt
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic done
);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == SETTLE_C);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux, assembles a 4-bit snapshot and hands it off over valid/ready.
// Optional MUX_SCAN_AUTO_EN: restart the scan directly after each accepted word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t            state;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] word_nxt;
    logic              done;

    // Counter runs only inside SCAN and restarts at every channel boundary.
    mux_scan_settle_cnt #(.SETTLE(SETTLE)) u_settle (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  ((state != SCAN) || done),
        .inc  (state == SCAN),
        .done (done)
    );

    // Full word including the bit being sampled this cycle.
    always_comb begin
        word_nxt      = capture;
        word_nxt[sel] = mux_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            capture    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (done) begin
                        capture[sel] <= mux_out;
                        if (sel == LAST_CH) begin
                            state      <= HOLD;
                            data_out   <= word_nxt;
                            data_valid <= 1'b1;
                            sel        <= '0;
                        end else begin
                            sel <= sel + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (data_valid && data_ready) begin
                        data_valid <= 1'b0;
`ifdef MUX_SCAN_AUTO_EN
                        state      <= SCAN;
                        sel        <= '0;
`else
                        state      <= IDLE;
                        busy       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed checks of mux_scan_ctrl with SETTLE=1 (u0) and SETTLE=0 (u1).
module tb_mux_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1, rdy0, rdy1;
    logic [3:0] in0, in1;
    logic [1:0] sel0, sel1;
    logic [3:0] dout0, dout1;
    logic       vld0, vld1, busy0, busy1;
    logic       mo0, mo1;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign mo0 = in0[sel0];
    assign mo1 = in1[sel1];

    mux_scan_ctrl #(.SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sel(sel0), .mux_out(mo0),
        .data_out(dout0), .data_valid(vld0), .data_ready(rdy0), .busy(busy0)
    );

    mux_scan_ctrl #(.SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sel(sel1), .mux_out(mo1),
        .data_out(dout1), .data_valid(vld1), .data_ready(rdy1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pulse0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0; in0 = 4'b0; in1 = 4'b0;
        tick(); tick();
        chk("rst_sel", {2'b0, sel0}, 4'd0);
        chk("rst_dout", dout0, 4'b0000);
        chk("rst_vld", {3'b0, vld0}, 4'd0);
        chk("rst_busy", {3'b0, busy0}, 4'd0);
        chk("rst_busy1", {3'b0, busy1}, 4'd0);
        rst_n = 1'b1;
        tick();

`ifndef MUX_SCAN_AUTO_EN
        // Basic scan, SETTLE=1, ready held high
        in0 = 4'b1010; rdy0 = 1'b1;
        pulse0();
        chk("scan_busy", {3'b0, busy0}, 4'd1);
        repeat (7) tick();
        chk("lat7_vld", {3'b0, vld0}, 4'd0);
        tick();
        chk("lat8_vld", {3'b0, vld0}, 4'd1);
        chk("word_1010", dout0, 4'b1010);
        chk("hold_sel", {2'b0, sel0}, 4'd0);
        tick();
        chk("acc_vld", {3'b0, vld0}, 4'd0);
        chk("acc_idle", {3'b0, busy0}, 4'd0);
        chk("dout_kept", dout0, 4'b1010);

        // Backpressure: ready low for 5 cycles, start pulses in HOLD ignored
        in0 = 4'b0101; rdy0 = 1'b0;
        pulse0();
        repeat (8) tick();
        chk("bp_vld", {3'b0, vld0}, 4'd1);
        chk("bp_word", dout0, 4'b0101);
        in0 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            start0 = i[0];
            tick();
            chk("bp_hold_vld", {3'b0, vld0}, 4'd1);
            chk("bp_hold_dout", dout0, 4'b0101);
        end
        start0 = 1'b0;
        rdy0 = 1'b1;
        tick();
        chk("bp_acc_vld", {3'b0, vld0}, 4'd0);
        chk("bp_acc_idle", {3'b0, busy0}, 4'd0);
        tick();
        chk("no_queue", {3'b0, busy0}, 4'd0);

        // SETTLE=0: one channel per cycle
        in1 = 4'b0110; rdy1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("s0_sel", {2'b0, sel1}, 4'(c));
            chk("s0_vld_lo", {3'b0, vld1}, 4'd0);
            if (c < 3) tick();
        end
        tick();
        chk("s0_vld", {3'b0, vld1}, 4'd1);
        chk("s0_word", dout1, 4'b0110);

        // Reset at the edge where sel==2
        in0 = 4'b1111;
        pulse0();
        repeat (4) tick();
        chk("pre_rst_sel", {2'b0, sel0}, 4'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", {3'b0, busy0}, 4'd0);
        chk("mid_rst_sel", {2'b0, sel0}, 4'd0);
        chk("mid_rst_dout", dout0, 4'b0000);
        chk("mid_rst_vld", {3'b0, vld0}, 4'd0);
        repeat (8) tick();
        chk("post_rst_vld", {3'b0, vld0}, 4'd0);
        chk("post_rst_busy", {3'b0, busy0}, 4'd0);
`else
        // Free-running: words 9 cycles apart with ready high
        in0 = 4'b0001; rdy0 = 1'b1;
        pulse0();
        repeat (8) tick();
        chk("auto_vld1", {3'b0, vld0}, 4'd1);
        chk("auto_word1", dout0, 4'b0001);
        in0 = 4'b1000;
        tick();
        chk("auto_acc_vld", {3'b0, vld0}, 4'd0);
        chk("auto_busy", {3'b0, busy0}, 4'd1);
        repeat (7) tick();
        chk("auto_gap_vld", {3'b0, vld0}, 4'd0);
        tick();
        chk("auto_vld2", {3'b0, vld0}, 4'd1);
        chk("auto_word2", dout0, 4'b1000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("auto_rst_busy", {3'b0, busy0}, 4'd0);
        chk("auto_rst_vld", {3'b0, vld0}, 4'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
